// File: rtl/axi_cache_pkg.sv
// Shared types and constants for the I/D cache AXI arbiter: FSM state encodings,
// burst constants, default IDs and the cache-line compare used by the hazard check.
package axi_cache_pkg;

    localparam int         OFFSET_WIDTH_DEF = 5;
    localparam logic [3:0] ID_I_DEF         = 4'd0;
    localparam logic [3:0] ID_D_DEF         = 4'd1;
    localparam logic [1:0] BURST_INCR       = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
    } ax_req_t;

    // Two addresses hit the same cache line when everything above the line offset matches.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b, input int ow);
        return (a >> ow) == (b >> ow);
    endfunction

endpackage

// File: rtl/axi_rd_grant.sv
// Read grant selection for the cache arbiter. Fixed D-cache priority by default;
// with ARB_RR_EN defined a registered round-robin pointer picks between the caches.
module axi_rd_grant (
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic rd_done,
    input  logic done_owner_d,
`endif
    input  logic i_req,
    input  logic d_req,
    input  logic d_block,
    output logic grant_valid,
    output logic grant_d
);

    logic d_ok;
    assign d_ok = d_req & ~d_block;

`ifdef ARB_RR_EN
    logic prefer_d_q;
    logic prefer_d_d;

    // After each finished burst the other master gets first claim on the next one.
    always_comb begin
        prefer_d_d = prefer_d_q;
        if (rd_done) begin
            prefer_d_d = ~done_owner_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_d_q <= 1'b1;
        end else begin
            prefer_d_q <= prefer_d_d;
        end
    end

    always_comb begin
        grant_valid = d_ok | i_req;
        grant_d     = d_ok & (prefer_d_q | ~i_req);
    end
`else
    always_comb begin
        grant_valid = d_ok | i_req;
        grant_d     = d_ok;
    end
`endif

endmodule

// File: rtl/axi_cache_arbiter.sv
// Shares one AXI3 master port between the I-cache (reads) and D-cache (reads + write-backs),
// holding back D refills of a line still being written back. Define ARB_RR_EN for round-robin reads.
module axi_cache_arbiter
    import axi_cache_pkg::*;
#(
    parameter int         OFFSET_WIDTH = OFFSET_WIDTH_DEF,
    parameter logic [3:0] ID_I         = ID_I_DEF,
    parameter logic [3:0] ID_D         = ID_D_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic [31:0] d_araddr,
    input  logic [3:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    input  logic [31:0] d_awaddr,
    input  logic [3:0]  d_awlen,
    input  logic [2:0]  d_awsize,
    input  logic        d_awvalid,
    output logic        d_awready,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_wlast,
    input  logic        d_wvalid,
    output logic        d_wready,
    output logic        d_bvalid,
    input  logic        d_bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      owner_d_q, owner_d_d;
    ax_req_t   aw_q, aw_d;
    logic      grant_valid, grant_d, d_block, rd_done;
    logic      unused_sig;

    // Only one burst is ever outstanding, so the returned IDs carry no routing information.
    assign unused_sig = ^{rid, bid, rd_done};

    // A write-back being accepted this cycle also wins over a same-line refill.
    assign d_block = ((wr_state_q != W_IDLE) && same_line(d_araddr, aw_q.addr, OFFSET_WIDTH)) ||
                     ((wr_state_q == W_IDLE) && d_awvalid && same_line(d_araddr, d_awaddr, OFFSET_WIDTH));

    axi_rd_grant u_rd_grant (
`ifdef ARB_RR_EN
        .clk          (clk),
        .rst          (rst),
        .rd_done      (rd_done),
        .done_owner_d (owner_d_q),
`endif
        .i_req        (i_arvalid),
        .d_req        (d_arvalid),
        .d_block      (d_block),
        .grant_valid  (grant_valid),
        .grant_d      (grant_d)
    );

    assign arid    = owner_d_q ? ID_D : ID_I;
    assign araddr  = owner_d_q ? d_araddr : i_araddr;
    assign arlen   = owner_d_q ? d_arlen : i_arlen;
    assign arsize  = owner_d_q ? d_arsize : i_arsize;
    assign arburst = BURST_INCR;
    assign i_rdata = rdata;
    assign d_rdata = rdata;
    assign i_rlast = rlast;
    assign d_rlast = rlast;

    always_comb begin
        rd_state_d = rd_state_q;
        owner_d_d  = owner_d_q;
        rd_done    = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        i_arready  = 1'b0;
        d_arready  = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (grant_valid) begin
                    owner_d_d  = grant_d;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                arvalid   = 1'b1;
                d_arready = owner_d_q & arready;
                i_arready = ~owner_d_q & arready;
                if (arready) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rready   = owner_d_q ? d_rready : i_rready;
                d_rvalid = owner_d_q & rvalid;
                i_rvalid = ~owner_d_q & rvalid;
                if (rvalid && rready && rlast) begin
                    rd_done    = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign awid    = ID_D;
    assign awaddr  = aw_q.addr;
    assign awlen   = aw_q.len;
    assign awsize  = aw_q.size;
    assign awburst = BURST_INCR;
    assign wid     = ID_D;
    assign wdata   = d_wdata;
    assign wstrb   = d_wstrb;
    assign wlast   = d_wlast;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_d       = aw_q;
        awvalid    = 1'b0;
        d_awready  = 1'b0;
        wvalid     = 1'b0;
        d_wready   = 1'b0;
        bready     = 1'b0;
        d_bvalid   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (d_awvalid) begin
                    aw_d       = '{addr: d_awaddr, len: d_awlen, size: d_awsize};
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                awvalid   = 1'b1;
                d_awready = awready;
                if (awready) begin
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wvalid   = d_wvalid;
                d_wready = wready;
                if (d_wvalid && wready && d_wlast) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bready   = d_bready;
                d_bvalid = bvalid;
                if (bvalid && d_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            owner_d_q  <= 1'b0;
            aw_q       <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            owner_d_q  <= owner_d_d;
            aw_q       <= aw_d;
        end
    end

endmodule
